// File: rtl/proc_pkg.sv
// proc_pkg: opcode constants, default widths and the decoded-control struct shared by the decode stage.
package proc_pkg;
    localparam int INSTR_W_DEF     = 20;
    localparam int OP_W_DEF        = 4;
    localparam int REG_AW_DEF      = 4;
    localparam int STALL_CNT_W_DEF = 16;
    // dest is carried at a fixed maximum width so the struct works for any REG_AW up to this
    localparam int REG_AW_MAX      = 8;

    localparam logic [OP_W_DEF-1:0] OP_NOP   = 4'b0000;
    localparam logic [OP_W_DEF-1:0] OP_LOAD  = 4'b1011;
    localparam logic [OP_W_DEF-1:0] OP_STORE = 4'b1100;

    typedef struct packed {
        logic [REG_AW_MAX-1:0] dest;
        logic                  wr_en;
        logic                  is_load;
        logic                  is_store;
        logic                  uses1;
        logic                  uses2;
    } ctrl_t;
endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: IF/ID-side inputs, register-file read addresses and ID/EX outputs of the decode stage.
interface id_decode_stage_if
    import proc_pkg::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
);
    logic                   in_valid;
    logic [INSTR_W-1:0]     in_instr;
    logic                   ex_hold;
    logic                   flush;
    logic                   stall;
    logic [REG_AW-1:0]      rd_addr1;
    logic [REG_AW-1:0]      rd_addr2;
    logic                   ex_valid;
    logic [INSTR_W-1:0]     ex_instr;
    logic [REG_AW-1:0]      ex_dest;
    logic                   ex_wr_en;
    logic                   ex_is_load;
    logic                   ex_is_store;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output in_valid, in_instr, ex_hold, flush,
        input  stall, rd_addr1, rd_addr2, ex_valid, ex_instr, ex_dest,
               ex_wr_en, ex_is_load, ex_is_store, stall_count
    );
    modport slave (
        input  in_valid, in_instr, ex_hold, flush,
        output stall, rd_addr1, rd_addr2, ex_valid, ex_instr, ex_dest,
               ex_wr_en, ex_is_load, ex_is_store, stall_count
    );
endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational field extraction, read-address selection and control decode.
module instr_field_decode
    import proc_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    localparam int LSB    = INSTR_W - OP_W - 3 * REG_AW
) (
    input  logic [INSTR_W-1:LSB] instr,
    output logic [REG_AW-1:0]    rd_addr1,
    output logic [REG_AW-1:0]    rd_addr2,
    output ctrl_t                ctrl
);
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] f1, f2, f3;
    logic              is_nop, is_load, is_store, is_alu;

    assign op = instr[INSTR_W-1 -: OP_W];
    assign f1 = instr[INSTR_W-OP_W-1 -: REG_AW];
    assign f2 = instr[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
    assign f3 = instr[INSTR_W-OP_W-2*REG_AW-1 -: REG_AW];

    always_comb begin
        is_nop         = op == OP_W'(OP_NOP);
        is_load        = op == OP_W'(OP_LOAD);
        is_store       = op == OP_W'(OP_STORE);
        is_alu         = !(is_nop || is_load || is_store);
        // STORE reads its data register from f1 as well as its base from f2
        rd_addr1       = is_store ? f1 : f2;
        rd_addr2       = is_store ? f2 : f3;
        ctrl.wr_en     = is_alu || is_load;
        ctrl.dest      = ctrl.wr_en ? REG_AW_MAX'(f1) : '0;
        ctrl.is_load   = is_load;
        ctrl.is_store  = is_store;
        ctrl.uses1     = !is_nop;
        ctrl.uses2     = is_alu || is_store;
    end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: decode, load-use hazard bubble insertion, ID/EX register with hold/flush, saturating stall counter.
module id_decode_stage
    import proc_pkg::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF,
    localparam int LSB        = INSTR_W - OP_W - 3 * REG_AW
) (
    input logic               clock,
    input logic               reset,
    id_decode_stage_if.slave  bus
);
    ctrl_t                  ctrl;
    logic [REG_AW-1:0]      a1, a2;
    logic                   haz, stall, go;
    logic                   ex_valid_d, ex_valid_q;
    logic [INSTR_W-1:0]     ex_instr_d, ex_instr_q;
    logic [REG_AW_MAX-1:0]  ex_dest_d, ex_dest_q;
    logic                   ex_wr_en_d, ex_wr_en_q;
    logic                   ex_is_load_d, ex_is_load_q;
    logic                   ex_is_store_d, ex_is_store_q;
    logic [STALL_CNT_W-1:0] stall_count_d, stall_count_q;

    instr_field_decode #(.INSTR_W(INSTR_W), .OP_W(OP_W), .REG_AW(REG_AW)) u_dec (
        .instr    (bus.in_instr[INSTR_W-1:LSB]),
        .rd_addr1 (a1),
        .rd_addr2 (a2),
        .ctrl     (ctrl)
    );

    always_comb begin
        haz   = bus.in_valid && ex_valid_q && ex_is_load_q &&
                ((ctrl.uses1 && REG_AW_MAX'(a1) == ex_dest_q) ||
                 (ctrl.uses2 && REG_AW_MAX'(a2) == ex_dest_q));
        stall = haz || bus.ex_hold;
        go    = bus.in_valid && !haz;
        ex_valid_d    = ex_valid_q;
        ex_instr_d    = ex_instr_q;
        ex_dest_d     = ex_dest_q;
        ex_wr_en_d    = ex_wr_en_q;
        ex_is_load_d  = ex_is_load_q;
        ex_is_store_d = ex_is_store_q;
        // flush beats hold; a hazard loads a bubble through the same zeroing path as in_valid=0
        if (bus.flush || !bus.ex_hold) begin
            ex_valid_d    = !bus.flush && go;
            ex_instr_d    = (!bus.flush && go) ? bus.in_instr : '0;
            ex_dest_d     = (!bus.flush && go) ? ctrl.dest : '0;
            ex_wr_en_d    = !bus.flush && go && ctrl.wr_en;
            ex_is_load_d  = !bus.flush && go && ctrl.is_load;
            ex_is_store_d = !bus.flush && go && ctrl.is_store;
        end
        stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_instr_q    <= '0;
            ex_dest_q     <= '0;
            ex_wr_en_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_is_store_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_instr_q    <= ex_instr_d;
            ex_dest_q     <= ex_dest_d;
            ex_wr_en_q    <= ex_wr_en_d;
            ex_is_load_q  <= ex_is_load_d;
            ex_is_store_q <= ex_is_store_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.rd_addr1    = a1;
    assign bus.rd_addr2    = a2;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_instr    = ex_instr_q;
    assign bus.ex_dest     = ex_dest_q[REG_AW-1:0];
    assign bus.ex_wr_en    = ex_wr_en_q;
    assign bus.ex_is_load  = ex_is_load_q;
    assign bus.ex_is_store = ex_is_store_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed tests of decode, load-use bubble, hold/flush and counter saturation.
module tb_id_decode_stage;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_decode_stage_if b0 ();
    id_decode_stage_if #(.STALL_CNT_W(2)) b1 ();

    id_decode_stage u0 (.clock(clock), .reset(reset), .bus(b0));
    id_decode_stage #(.STALL_CNT_W(2)) u1 (.clock(clock), .reset(reset), .bus(b1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b0.in_valid = 1'b0; b0.in_instr = '0; b0.ex_hold = 1'b0; b0.flush = 1'b0;
        b1.in_valid = 1'b0; b1.in_instr = '0; b1.ex_hold = 1'b0; b1.flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b exp 0", b0.ex_valid); end
        checks++; if (b0.ex_instr !== 20'h0) begin errors++; $display("FAIL reset_ex_instr: got %h exp 0", b0.ex_instr); end
        checks++; if (b0.stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", b0.stall_count); end
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", b0.stall); end
    endtask

    task automatic test_alu();
        b0.in_valid = 1'b1; b0.in_instr = 20'h13450;
        #1;
        checks++; if (b0.rd_addr1 !== 4'd4) begin errors++; $display("FAIL alu_rd1: got %0d exp 4", b0.rd_addr1); end
        checks++; if (b0.rd_addr2 !== 4'd5) begin errors++; $display("FAIL alu_rd2: got %0d exp 5", b0.rd_addr2); end
        tick();
        checks++; if (b0.ex_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b exp 1", b0.ex_valid); end
        checks++; if (b0.ex_dest !== 4'd3) begin errors++; $display("FAIL alu_dest: got %0d exp 3", b0.ex_dest); end
        checks++; if (b0.ex_wr_en !== 1'b1) begin errors++; $display("FAIL alu_wr_en: got %b exp 1", b0.ex_wr_en); end
        checks++; if (b0.ex_instr !== 20'h13450) begin errors++; $display("FAIL alu_instr: got %h exp 13450", b0.ex_instr); end
        checks++; if (b0.ex_is_load !== 1'b0) begin errors++; $display("FAIL alu_is_load: got %b exp 0", b0.ex_is_load); end
    endtask

    task automatic test_store();
        b0.in_instr = 20'hC2700;
        #1;
        checks++; if (b0.rd_addr1 !== 4'd2) begin errors++; $display("FAIL st_rd1: got %0d exp 2", b0.rd_addr1); end
        checks++; if (b0.rd_addr2 !== 4'd7) begin errors++; $display("FAIL st_rd2: got %0d exp 7", b0.rd_addr2); end
        tick();
        checks++; if (b0.ex_is_store !== 1'b1) begin errors++; $display("FAIL st_is_store: got %b exp 1", b0.ex_is_store); end
        checks++; if (b0.ex_wr_en !== 1'b0) begin errors++; $display("FAIL st_wr_en: got %b exp 0", b0.ex_wr_en); end
        checks++; if (b0.ex_dest !== 4'd0) begin errors++; $display("FAIL st_dest: got %0d exp 0", b0.ex_dest); end
    endtask

    task automatic test_load_use();
        b0.in_valid = 1'b0;
        tick();
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_idle_valid: got %b exp 0", b0.ex_valid); end
        b0.in_valid = 1'b1; b0.in_instr = 20'hB6100;
        #1;
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL lu_load_stall: got %b exp 0", b0.stall); end
        tick();
        b0.in_instr = 20'h12630;
        #1;
        checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL lu_haz_stall: got %b exp 1", b0.stall); end
        tick();
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b exp 0", b0.ex_valid); end
        checks++; if (b0.ex_is_load !== 1'b0) begin errors++; $display("FAIL lu_bubble_load: got %b exp 0", b0.ex_is_load); end
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL lu_after_stall: got %b exp 0", b0.stall); end
        checks++; if (b0.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d exp 1", b0.stall_count); end
        tick();
        checks++; if (b0.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_adv_valid: got %b exp 1", b0.ex_valid); end
        checks++; if (b0.ex_instr !== 20'h12630) begin errors++; $display("FAIL lu_adv_instr: got %h exp 12630", b0.ex_instr); end
        checks++; if (b0.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold: got %0d exp 1", b0.stall_count); end
    endtask

    task automatic test_hazard_sources();
        b0.in_instr = 20'hB6100;
        tick();
        b0.in_instr = 20'h12930;
        #1;
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL hs_nomatch_stall: got %b exp 0", b0.stall); end
        tick();
        checks++; if (b0.ex_dest !== 4'd2) begin errors++; $display("FAIL hs_nomatch_dest: got %0d exp 2", b0.ex_dest); end
        b0.in_instr = 20'hB6100;
        tick();
        b0.in_instr = 20'hB4600;
        #1;
        checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL hs_base_stall: got %b exp 1", b0.stall); end
        tick();
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL hs_base_bubble: got %b exp 0", b0.ex_valid); end
        tick();
        checks++; if (b0.ex_dest !== 4'd4) begin errors++; $display("FAIL hs_base_dest: got %0d exp 4", b0.ex_dest); end
        b0.in_instr = 20'hB6100;
        #1;
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL hs_diff_dest_stall: got %b exp 0", b0.stall); end
        tick();
        b0.in_instr = 20'hB5160;
        #1;
        checks++; if (b0.rd_addr2 !== 4'd6) begin errors++; $display("FAIL hs_f3_rd2: got %0d exp 6", b0.rd_addr2); end
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL hs_f3_stall: got %b exp 0", b0.stall); end
        tick();
        checks++; if (b0.ex_dest !== 4'd5) begin errors++; $display("FAIL hs_f3_dest: got %0d exp 5", b0.ex_dest); end
        checks++; if (b0.stall_count !== 16'd2) begin errors++; $display("FAIL hs_count: got %0d exp 2", b0.stall_count); end
    endtask

    task automatic test_hold_flush();
        b0.in_instr = 20'h12930;
        tick();
        b0.ex_hold = 1'b1; b0.in_instr = 20'h13450;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %b exp 1", i, b0.stall); end
            tick();
            checks++; if (b0.ex_instr !== 20'h12930 || b0.ex_valid !== 1'b1 || b0.ex_dest !== 4'd2)
                begin errors++; $display("FAIL hold_frozen[%0d]: got %h/%b/%0d exp 12930/1/2", i, b0.ex_instr, b0.ex_valid, b0.ex_dest); end
        end
        checks++; if (b0.stall_count !== 16'd5) begin errors++; $display("FAIL hold_count: got %0d exp 5", b0.stall_count); end
        b0.flush = 1'b1;
        tick();
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL hold_flush_valid: got %b exp 0", b0.ex_valid); end
        checks++; if (b0.stall_count !== 16'd6) begin errors++; $display("FAIL hold_flush_count: got %0d exp 6", b0.stall_count); end
        b0.flush = 1'b0; b0.ex_hold = 1'b0;
    endtask

    task automatic test_flush_haz();
        b0.in_instr = 20'hB6100;
        tick();
        b0.in_instr = 20'h12630; b0.flush = 1'b1;
        #1;
        checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL fh_stall: got %b exp 1", b0.stall); end
        tick();
        checks++; if (b0.ex_valid !== 1'b0) begin errors++; $display("FAIL fh_valid: got %b exp 0", b0.ex_valid); end
        checks++; if (b0.stall_count !== 16'd7) begin errors++; $display("FAIL fh_count: got %0d exp 7", b0.stall_count); end
        b0.flush = 1'b0;
        #1;
        checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL fh_after_stall: got %b exp 0", b0.stall); end
        tick();
        checks++; if (b0.ex_valid !== 1'b1 || b0.ex_dest !== 4'd2) begin errors++; $display("FAIL fh_adv: got %b/%0d exp 1/2", b0.ex_valid, b0.ex_dest); end
    endtask

    task automatic test_saturate_reset();
        b1.in_valid = 1'b1; b1.in_instr = 20'h13450;
        tick();
        b1.ex_hold = 1'b1;
        tick(); tick();
        checks++; if (b1.stall_count !== 2'd2) begin errors++; $display("FAIL sat_count2: got %0d exp 2", b1.stall_count); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (b1.stall_count !== 2'd3) begin errors++; $display("FAIL sat_count3: got %0d exp 3", b1.stall_count); end
        checks++; if (b1.ex_valid !== 1'b1 || b1.ex_instr !== 20'h13450) begin errors++; $display("FAIL sat_frozen: got %b/%h exp 1/13450", b1.ex_valid, b1.ex_instr); end
        reset = 1'b1;
        tick();
        checks++; if (b1.ex_valid !== 1'b0 || b1.ex_instr !== 20'h0 || b1.ex_dest !== 4'd0 || b1.ex_wr_en !== 1'b0)
            begin errors++; $display("FAIL rst_stall_ex: got %b/%h/%0d/%b exp 0/0/0/0", b1.ex_valid, b1.ex_instr, b1.ex_dest, b1.ex_wr_en); end
        checks++; if (b1.stall_count !== 2'd0) begin errors++; $display("FAIL rst_stall_count: got %0d exp 0", b1.stall_count); end
        checks++; if (b0.stall_count !== 16'd0 || b0.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_u0: got %0d/%b exp 0/0", b0.stall_count, b0.ex_valid); end
        reset = 1'b0;
        #1;
        checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL rst_hold_stall: got %b exp 1", b1.stall); end
        checks++; if (b1.rd_addr1 !== 4'd4) begin errors++; $display("FAIL rst_rd1: got %0d exp 4", b1.rd_addr1); end
        b1.ex_hold = 1'b0;
        #1;
        checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rst_free_stall: got %b exp 0", b1.stall); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_use();
        test_hazard_sources();
        test_hold_flush();
        test_flush_haz();
        test_saturate_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
